step_flag_gen: RTL and testbench
================================

Name: step_flag_gen

Overview:
- Drives a step-count register toward a requested target value.
- Emits one-cycle increment (flag_light_1) and decrement (flag_light_2) pulses, spaced by a programmable gap.
- Feeds any up/down step counter that adds 1 on flag_light_1, subtracts 1 on flag_light_2 and wraps modulo 2^WIDTH.
- Keeps a shadow copy of the downstream count so it can plan direction and step count, and reports completion with a done pulse.

Parameters:
WIDTH, 4, counter width in bits; all arithmetic is modulo 2^WIDTH.
GAP_CYCLES, 1, number of idle cycles (both flags low) between consecutive step pulses; range 0..255.
SHORTEST, 1, 1 = take the wrap-aware shortest direction; 0 = plain magnitude compare, never wrap.

Ports:
FPGA_CLK  in  1  system clock; all logic on the rising edge.
FPGA_RST  in  1  synchronous, active-high reset.
target  in  WIDTH  requested count; sampled only on an accepted start.
start  in  1  request; accepted when start & ready on a rising edge.
ready  out  1  high when idle and able to accept start.
flag_light_1  out  1  registered one-cycle increment pulse.
flag_light_2  out  1  registered one-cycle decrement pulse.
done  out  1  one-cycle pulse when the shadow count equals the latched target.
cur_count  out  WIDTH  shadow of the downstream count.

Behaviour:
- Clock and reset: one clock (FPGA_CLK). Reset is synchronous and active-high (FPGA_RST).
- Reset values:
  - state = IDLE, ready = 1.
  - flag_light_1 = flag_light_2 = 0, done = 0.
  - cur_count = 0, gap counter = 0, latched target = 0.
  - The downstream counter must be cleared by the same FPGA_RST so that cur_count matches it.
- States:
  - IDLE:
    - ready = 1.
    - On start: latch target, compute direction, clear ready at the same edge.
    - If target == cur_count, go to DONE; else go to STEP.
  - STEP:
    - Exactly one flag is high for this single cycle.
    - At the edge ending STEP, cur_count is updated ±1 (mod 2^WIDTH), matching the downstream counter's update at the same edge.
    - If the new cur_count == latched target, go to DONE.
    - Else if GAP_CYCLES == 0, go to STEP (back-to-back pulses).
    - Else go to GAP.
  - GAP: both flags low; count GAP_CYCLES cycles, then go to STEP.
  - DONE: done = 1 for one cycle, ready = 0; then go to IDLE.
- Direction (fixed for the whole job, computed once at accept):
  - SHORTEST = 1: d = (target - cur_count) mod 2^WIDTH. Go up if d <= 2^(WIDTH-1), else down. The tie d = 2^(WIDTH-1) goes up.
  - SHORTEST = 0: up if target > cur_count, else down.
- Invariants:
  - flag_light_1 and flag_light_2 are never high in the same cycle.
  - Neither flag is ever high outside STEP.
- Latency, with accept at edge 0 and N steps:
  - Pulses occur in cycles 1, 1+(GAP_CYCLES+1), ... up to N pulses.
  - done is high in cycle N*(GAP_CYCLES+1) - GAP_CYCLES + 1.
  - ready returns 1 the cycle after done.
  - target == cur_count at accept: done in cycle 1, no pulses.
- start while ready = 0: ignored, no queueing. target changes while busy have no effect.
- Reset mid-job: at that edge the flags drop to 0, done is not asserted, and the block returns to IDLE with cur_count = 0.

Decomposition:
- Shared package step_pkg:
  - state enum {IDLE, STEP, GAP, DONE}.
  - direction encoding DIR_UP / DIR_DN.
  - default WIDTH and GAP_CYCLES constants.
- One sub-module: step_gap_timer.
  - Loadable down-counter, 8 bits.
  - Inputs: load, enable. Output: expired.
  - Instantiated once for the GAP state.

Test Plan:
1. Reset, then start with target = 3, GAP_CYCLES = 1 -> flag_light_1 high in cycles 1, 3, 5; flag_light_2 never high; cur_count goes 1, 2, 3; done in cycle 6; ready = 1 in cycle 7.
2. cur_count = 0, target = 14, SHORTEST = 1 -> flag_light_2 pulses twice; cur_count goes 15, 14; done after the second pulse. With SHORTEST = 0 -> 14 flag_light_1 pulses instead.
3. cur_count = 0, target = 8 (tie), SHORTEST = 1 -> 8 flag_light_1 pulses; cur_count = 8 at done.
4. start with target == cur_count = 5 -> no flags; done in cycle 1; ready = 1 in cycle 2.
5. GAP_CYCLES = 0, target = 2 from 0 -> flag_light_1 high in cycles 1 and 2 back-to-back; done in cycle 3. Pulse start every cycle while busy -> no effect on the pulse train.
6. Assert FPGA_RST during the GAP of a 5-step job -> next cycle flags = 0, done = 0, ready = 1, cur_count = 0. A reference counter model in the bench must match cur_count at every cycle.

Source files
------------

// File: rtl/step_pkg.sv
// ---------------------------------------------------------------------------
// step_pkg
// Shared types and constants for the step flag generator.
//   step_state_e : controller states (IDLE, STEP, GAP, DONE)
//   step_dir_e   : stepping direction, fixed for a whole job
//   DEFAULT_*    : default parameter values for step_flag_gen
//   TIMER_WIDTH  : width of the inter-pulse gap counter
// ---------------------------------------------------------------------------
package step_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } step_state_e;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } step_dir_e;

  localparam int DEFAULT_WIDTH      = 4;
  localparam int DEFAULT_GAP_CYCLES = 1;
  localparam int TIMER_WIDTH        = 8;

endpackage

// File: rtl/step_gap_timer.sv
// ---------------------------------------------------------------------------
// step_gap_timer
// Loadable 8-bit down-counter that times the idle gap between step pulses.
// Ports:
//   FPGA_CLK   in   system clock
//   FPGA_RST   in   synchronous active-high reset (counter cleared to 0)
//   load       in   load load_value into the counter
//   load_value in   gap length in cycles
//   enable     in   count down by one this cycle (saturates at 0)
//   expired    out  high in the last cycle of the gap
// ---------------------------------------------------------------------------
module step_gap_timer
  import step_pkg::*;
(
  input  logic                   FPGA_CLK,
  input  logic                   FPGA_RST,
  input  logic                   load,
  input  logic [TIMER_WIDTH-1:0] load_value,
  input  logic                   enable,
  output logic                   expired
);

  logic [TIMER_WIDTH-1:0] count_r;

  // Gap counter: reload on load, otherwise count down while enabled, stop at zero
  always_ff @(posedge FPGA_CLK) begin
    if (FPGA_RST) begin
      count_r <= 8'd0;
    end else if (load) begin
      count_r <= load_value;
    end else if (enable && (count_r != 8'd0)) begin
      count_r <= count_r - 8'd1;
    end else begin
      count_r <= count_r;
    end
  end

  // The counter holds N in the first gap cycle and 1 in the last, so the gap
  // lasts exactly N cycles. Zero is treated as expired so a stale count can
  // never hold the controller in GAP.
  assign expired = (count_r <= 8'd1);

endmodule

// File: rtl/step_flag_gen.sv
// ---------------------------------------------------------------------------
// step_flag_gen
// Drives a downstream up/down counter toward a requested target by emitting
// one-cycle increment/decrement pulses separated by GAP_CYCLES idle cycles.
// A shadow copy of the downstream count is kept to plan each job.
// Ports:
//   FPGA_CLK      in   system clock, rising edge
//   FPGA_RST      in   synchronous active-high reset
//   target        in   requested count, sampled on an accepted start
//   start         in   job request, accepted when start & ready
//   ready         out  idle and able to accept start
//   flag_light_1  out  registered one-cycle increment pulse
//   flag_light_2  out  registered one-cycle decrement pulse
//   done          out  one-cycle pulse when the shadow count reaches target
//   cur_count     out  shadow of the downstream count
// ---------------------------------------------------------------------------
module step_flag_gen
  import step_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES,
  parameter bit SHORTEST   = 1'b1
) (
  input  logic             FPGA_CLK,
  input  logic             FPGA_RST,
  input  logic [WIDTH-1:0] target,
  input  logic             start,
  output logic             ready,
  output logic             flag_light_1,
  output logic             flag_light_2,
  output logic             done,
  output logic [WIDTH-1:0] cur_count
);

  // Half the modulus: a wrap distance equal to this is a tie and goes up.
  localparam logic [WIDTH-1:0]       HALF_RANGE = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0]       ONE        = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [TIMER_WIDTH-1:0] GAP_LOAD   = TIMER_WIDTH'(GAP_CYCLES);
  localparam bit                     NO_GAP     = (GAP_CYCLES == 0);

  step_state_e      state_r, next_state_s;
  step_dir_e        dir_r, next_dir_s, dir_calc_s;
  logic [WIDTH-1:0] target_r, next_target_s;
  logic [WIDTH-1:0] count_r, next_count_s;
  logic [WIDTH-1:0] diff_s;
  logic             timer_load_s;
  logic             timer_en_s;
  logic             timer_expired_s;
  logic             ready_r;
  logic             flag_up_r;
  logic             flag_dn_r;
  logic             done_r;

  step_gap_timer u_gap_timer (
    .FPGA_CLK   (FPGA_CLK),
    .FPGA_RST   (FPGA_RST),
    .load       (timer_load_s),
    .load_value (GAP_LOAD),
    .enable     (timer_en_s),
    .expired    (timer_expired_s)
  );

  // Direction for a job starting now, from the live target and shadow count
  always_comb begin
    diff_s     = target - count_r;
    dir_calc_s = DIR_UP;
    if (SHORTEST) begin
      if (diff_s <= HALF_RANGE) begin
        dir_calc_s = DIR_UP;
      end else begin
        dir_calc_s = DIR_DN;
      end
    end else begin
      if (target > count_r) begin
        dir_calc_s = DIR_UP;
      end else begin
        dir_calc_s = DIR_DN;
      end
    end
  end

  // Controller next state, job context and gap timer control
  always_comb begin
    next_state_s  = state_r;
    next_dir_s    = dir_r;
    next_target_s = target_r;
    next_count_s  = count_r;
    timer_load_s  = 1'b0;
    timer_en_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          next_target_s = target;
          next_dir_s    = dir_calc_s;
          if (target == count_r) begin
            next_state_s = DONE;
          end else begin
            next_state_s = STEP;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      STEP: begin
        // Shadow count moves at the same edge the downstream counter does.
        if (dir_r == DIR_UP) begin
          next_count_s = count_r + ONE;
        end else begin
          next_count_s = count_r - ONE;
        end
        if (next_count_s == target_r) begin
          next_state_s = DONE;
        end else if (NO_GAP) begin
          next_state_s = STEP;
        end else begin
          next_state_s = GAP;
          timer_load_s = 1'b1;
        end
      end
      GAP: begin
        timer_en_s = 1'b1;
        if (timer_expired_s) begin
          next_state_s = STEP;
        end else begin
          next_state_s = GAP;
        end
      end
      DONE: begin
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State, job context and registered outputs decoded from the next state
  always_ff @(posedge FPGA_CLK) begin
    if (FPGA_RST) begin
      state_r   <= IDLE;
      dir_r     <= DIR_UP;
      target_r  <= {WIDTH{1'b0}};
      count_r   <= {WIDTH{1'b0}};
      ready_r   <= 1'b1;
      flag_up_r <= 1'b0;
      flag_dn_r <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      dir_r     <= next_dir_s;
      target_r  <= next_target_s;
      count_r   <= next_count_s;
      ready_r   <= (next_state_s == IDLE);
      flag_up_r <= (next_state_s == STEP) && (next_dir_s == DIR_UP);
      flag_dn_r <= (next_state_s == STEP) && (next_dir_s == DIR_DN);
      done_r    <= (next_state_s == DONE);
    end
  end

  assign ready        = ready_r;
  assign flag_light_1 = flag_up_r;
  assign flag_light_2 = flag_dn_r;
  assign done         = done_r;
  assign cur_count    = count_r;

endmodule

// File: tb/tb_step_flag_gen.sv
// ---------------------------------------------------------------------------
// tb_step_flag_gen
// Four step_flag_gen instances share one set of inputs:
//   u0: GAP=1 SHORTEST=1   u1: GAP=0 SHORTEST=1
//   u2: GAP=1 SHORTEST=0   u3: GAP=3 SHORTEST=1
// The reference model plans each job (direction, step count) with plain
// modular arithmetic and derives every cycle's outputs from the pulse
// schedule: pulse k in cycle 1+k*(G+1), done in cycle N*(G+1)-G+1.
// ---------------------------------------------------------------------------
module tb_step_flag_gen;

  localparam int NI = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          start;
  logic [3:0]    target;
  logic [NI-1:0] rdy, f1, f2, dn;
  logic [3:0]    cnt [NI];

  step_flag_gen #(.WIDTH(4), .GAP_CYCLES(1), .SHORTEST(1'b1)) u0 (
    .FPGA_CLK(clk), .FPGA_RST(rst), .target(target), .start(start), .ready(rdy[0]),
    .flag_light_1(f1[0]), .flag_light_2(f2[0]), .done(dn[0]), .cur_count(cnt[0]));
  step_flag_gen #(.WIDTH(4), .GAP_CYCLES(0), .SHORTEST(1'b1)) u1 (
    .FPGA_CLK(clk), .FPGA_RST(rst), .target(target), .start(start), .ready(rdy[1]),
    .flag_light_1(f1[1]), .flag_light_2(f2[1]), .done(dn[1]), .cur_count(cnt[1]));
  step_flag_gen #(.WIDTH(4), .GAP_CYCLES(1), .SHORTEST(1'b0)) u2 (
    .FPGA_CLK(clk), .FPGA_RST(rst), .target(target), .start(start), .ready(rdy[2]),
    .flag_light_1(f1[2]), .flag_light_2(f2[2]), .done(dn[2]), .cur_count(cnt[2]));
  step_flag_gen #(.WIDTH(4), .GAP_CYCLES(3), .SHORTEST(1'b1)) u3 (
    .FPGA_CLK(clk), .FPGA_RST(rst), .target(target), .start(start), .ready(rdy[3]),
    .flag_light_1(f1[3]), .flag_light_2(f2[3]), .done(dn[3]), .cur_count(cnt[3]));

  // Model state per instance
  bit busy [NI];
  bit up   [NI];
  int acc  [NI];
  int c0   [NI];
  int nst  [NI];
  int rest [NI];
  int cyc = 0;

  int vectors = 0;
  int miscompares = 0;

  function automatic int gap_of(int i);
    return (i == 1) ? 0 : ((i == 3) ? 3 : 1);
  endfunction

  function automatic bit shortest_of(int i);
    return (i != 2);
  endfunction

  function automatic int mod16(int v);
    return ((v % 16) + 16) % 16;
  endfunction

  function automatic int done_cyc(int i);
    int g;
    g = gap_of(i);
    return (nst[i] == 0) ? 1 : nst[i] * (g + 1) - g + 1;
  endfunction

  function automatic logic [7:0] exp_vec(int i);
    int j, g, p, pk, c;
    bit f;
    if (!busy[i]) return {1'b1, 3'b000, 4'(rest[i])};
    j = cyc - acc[i];
    g = gap_of(i);
    p = 0;
    f = 1'b0;
    for (int k = 0; k < nst[i]; k++) begin
      pk = 1 + k * (g + 1);
      if (pk < j) p++;
      if (pk == j) f = 1'b1;
    end
    c = up[i] ? mod16(c0[i] + p) : mod16(c0[i] - p);
    return {1'b0, f && up[i], f && !up[i], (j == done_cyc(i)), 4'(c)};
  endfunction

  function automatic logic [7:0] obs_vec(int i);
    return {rdy[i], f1[i], f2[i], dn[i], cnt[i]};
  endfunction

  // One clock: apply the inputs at the edge, advance the model, sample at negedge
  task automatic tick();
    bit rdy_pre [NI];
    int d, t;
    for (int i = 0; i < NI; i++) rdy_pre[i] = !busy[i];
    @(posedge clk);
    cyc++;
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        busy[i] = 1'b0;
        rest[i] = 0;
      end else if (start && rdy_pre[i]) begin
        busy[i] = 1'b1;
        acc[i]  = cyc - 1;
        c0[i]   = rest[i];
        t       = int'(target);
        if (shortest_of(i)) begin
          d      = mod16(t - c0[i]);
          up[i]  = (d <= 8);
          nst[i] = up[i] ? d : 16 - d;
        end else begin
          up[i]  = (t > c0[i]);
          nst[i] = up[i] ? t - c0[i] : c0[i] - t;
        end
      end
      if (busy[i] && (cyc - acc[i] > done_cyc(i))) begin
        busy[i] = 1'b0;
        rest[i] = up[i] ? mod16(c0[i] + nst[i]) : mod16(c0[i] - nst[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; target = 4'd0;
    tick();
    tick();
    for (int i = 0; i < NI; i++) begin
      vectors++;
      if (obs_vec(i) !== 8'b1000_0000) begin
        miscompares++;
        $display("FAIL reset inst%0d got=%b exp=%b", i, obs_vec(i), 8'b1000_0000);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_up_gap();
    target = 4'd3; start = 1'b1;
    tick();
    start = 1'b0; target = 4'($urandom);
    for (int n = 0; n < 12; n++) begin
      for (int i = 0; i < NI; i++) begin
        vectors++;
        if (obs_vec(i) !== exp_vec(i)) begin
          miscompares++;
          $display("FAIL up_gap inst%0d cyc%0d got=%b exp=%b", i, cyc, obs_vec(i), exp_vec(i));
        end
      end
      tick();
    end
    vectors++;
    if (cnt[0] !== 4'd3) begin
      miscompares++;
      $display("FAIL up_gap_final got=%0d exp=3", cnt[0]);
    end
  endtask

  task automatic test_shortest();
    rst = 1'b1; tick(); rst = 1'b0;
    target = 4'd14; start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NI; i++) begin
        vectors++;
        if (obs_vec(i) !== exp_vec(i)) begin
          miscompares++;
          $display("FAIL shortest inst%0d cyc%0d got=%b exp=%b", i, cyc, obs_vec(i), exp_vec(i));
        end
      end
      tick();
    end
  endtask

  task automatic test_tie();
    rst = 1'b1; tick(); rst = 1'b0;
    target = 4'd8; start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NI; i++) begin
        vectors++;
        if (obs_vec(i) !== exp_vec(i)) begin
          miscompares++;
          $display("FAIL tie inst%0d cyc%0d got=%b exp=%b", i, cyc, obs_vec(i), exp_vec(i));
        end
      end
      tick();
    end
    vectors++;
    if (cnt[0] !== 4'd8) begin
      miscompares++;
      $display("FAIL tie_final got=%0d exp=8", cnt[0]);
    end
  endtask

  task automatic test_equal();
    target = 4'd5; start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 40; n++) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < NI; i++) begin
        vectors++;
        if (obs_vec(i) !== exp_vec(i)) begin
          miscompares++;
          $display("FAIL equal inst%0d cyc%0d got=%b exp=%b", i, cyc, obs_vec(i), exp_vec(i));
        end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    rst = 1'b1; tick(); rst = 1'b0;
    target = 4'd2; start = 1'b1;
    tick();
    for (int n = 0; n < 44; n++) begin
      for (int i = 0; i < NI; i++) begin
        vectors++;
        if (obs_vec(i) !== exp_vec(i)) begin
          miscompares++;
          $display("FAIL back_to_back inst%0d cyc%0d got=%b exp=%b", i, cyc, obs_vec(i), exp_vec(i));
        end
      end
      target = 4'($urandom);
      start  = (n < 3);
      tick();
    end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1; tick(); rst = 1'b0;
    target = 4'd5; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int i = 0; i < NI; i++) begin
      vectors++;
      if (obs_vec(i) !== exp_vec(i)) begin
        miscompares++;
        $display("FAIL reset_mid_pre inst%0d cyc%0d got=%b exp=%b", i, cyc, obs_vec(i), exp_vec(i));
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NI; i++) begin
      vectors++;
      if (obs_vec(i) !== 8'b1000_0000) begin
        miscompares++;
        $display("FAIL reset_mid inst%0d got=%b exp=%b", i, obs_vec(i), 8'b1000_0000);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      start  = ($urandom_range(0, 2) == 0);
      target = 4'($urandom);
      rst    = ($urandom_range(0, 79) == 0);
      tick();
      for (int i = 0; i < NI; i++) begin
        vectors++;
        if (obs_vec(i) !== exp_vec(i)) begin
          miscompares++;
          $display("FAIL random inst%0d cyc%0d got=%b exp=%b", i, cyc, obs_vec(i), exp_vec(i));
        end
      end
    end
    rst = 1'b0; start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      busy[i] = 1'b0; up[i] = 1'b1; acc[i] = 0; c0[i] = 0; nst[i] = 0; rest[i] = 0;
    end
    test_reset();
    test_up_gap();
    test_shortest();
    test_tie();
    test_equal();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
